// File: rtl/replica_ram_sched_if.sv
// Purpose: host-side control and per-RAM command/select bundle for the replica RAM scheduler.
// Latency: none, wires only.
// Backpressure: none; start is sampled only while the scheduler is idle.
interface replica_ram_sched_if #(
    parameter int REPLICA_NUM = 16,
    parameter int ITER_W      = 16
);
    // Host request side
    logic                         start;
    logic [ITER_W-1:0]            iter_num;
    logic [REPLICA_NUM-2:0]       exch_grant;

    // Scheduler status and per-lane RAM control
    logic                         busy;
    logic                         done;
    logic                         exch_odd;
    logic [ITER_W-1:0]            iter_cnt;
    logic [REPLICA_NUM-1:0][1:0]  command;   // 0 NOP, 1 OPT, 2 EXC
    logic [REPLICA_NUM-1:0][1:0]  src_sel;   // 0 SELF, 1 PREV (idx-1), 2 FOLW (idx+1)

    // Host / testbench side
    modport master (
        output start, iter_num, exch_grant,
        input  busy, done, exch_odd, iter_cnt, command, src_sel
    );

    // Scheduler side
    modport slave (
        input  start, iter_num, exch_grant,
        output busy, done, exch_odd, iter_cnt, command, src_sel
    );
endinterface

// File: rtl/replica_ram_sched.sv
// Purpose: alternates OPT and EXC sweeps over all replica RAMs for a programmed iteration count.
// Latency: command 1 cycle after start; each phase CITY_NUM+2 cycles; done 1 cycle after last EXC_RUN.
// Backpressure: none; start ignored while busy. Optional REPLICA_EXCH_ODD_EN alternates pair parity.
module replica_ram_sched #(
    parameter int CITY_NUM    = 32,
    parameter int REPLICA_NUM = 16,
    parameter int ITER_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    replica_ram_sched_if.slave   bus
);
    localparam int PH_W = $clog2(CITY_NUM + 2);

    localparam logic [1:0] CMD_NOP  = 2'd0;
    localparam logic [1:0] CMD_OPT  = 2'd1;
    localparam logic [1:0] CMD_EXC  = 2'd2;
    localparam logic [1:0] SEL_SELF = 2'd0;
    localparam logic [1:0] SEL_PREV = 2'd1;
    localparam logic [1:0] SEL_FOLW = 2'd2;

    // Last phase-counter value: sweep of CITY_NUM addresses plus the write-lag drain
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CITY_NUM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPT_ISSUE,
        S_OPT_RUN,
        S_EXC_ISSUE,
        S_EXC_RUN,
        S_FIN
    } state_t;

    state_t                        state_q, state_d;
    logic [PH_W-1:0]               ph_q, ph_d;
    logic [ITER_W-1:0]             iter_cnt_q, iter_cnt_d;
    logic [ITER_W-1:0]             iter_num_q, iter_num_d;
    logic                          odd_q, odd_d;
    logic [REPLICA_NUM-1:0][1:0]   sel_q, sel_d;

    logic [REPLICA_NUM-2:0]        par_mask;
    logic [REPLICA_NUM-2:0]        pair_go;
    logic [REPLICA_NUM-1:0][1:0]   sel_new;
    logic [ITER_W-1:0]             cnt_inc;
    logic                          ph_end;

    assign cnt_inc = iter_cnt_q + ITER_W'(1);
    assign ph_end  = (ph_q == PH_LAST);

    // Pair selection: only pairs whose lower index matches the current parity may swap
    always_comb begin
        par_mask = '0;
        pair_go  = '0;
        sel_new  = '0;
        for (int k = 0; k < REPLICA_NUM - 1; k++) begin
            par_mask[k] = (1'(k % 2) == odd_q);
        end
        pair_go = bus.exch_grant & par_mask;
        // Same-parity pairs never share a lane, so these writes cannot collide
        for (int k = 0; k < REPLICA_NUM - 1; k++) begin
            if (pair_go[k]) begin
                sel_new[k]     = SEL_FOLW;
                sel_new[k + 1] = SEL_PREV;
            end
        end
    end

    // Next-state logic for the phase sequencer
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        iter_cnt_d = iter_cnt_q;
        iter_num_d = iter_num_q;
        odd_d      = odd_q;
        sel_d      = sel_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    iter_num_d = bus.iter_num;
                    iter_cnt_d = '0;
                    odd_d      = 1'b0;
                    // A zero-length run still reports completion, but touches no RAM
                    state_d    = (bus.iter_num == '0) ? S_FIN : S_OPT_ISSUE;
                end
            end
            S_OPT_ISSUE: begin
                ph_d    = '0;
                state_d = S_OPT_RUN;
            end
            S_OPT_RUN: begin
                if (ph_end) begin
                    state_d = S_EXC_ISSUE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_EXC_ISSUE: begin
                ph_d    = '0;
                // Grants are captured once here; selects then stay frozen for the whole sweep
                sel_d   = sel_new;
                state_d = S_EXC_RUN;
            end
            S_EXC_RUN: begin
                if (ph_end) begin
                    sel_d      = '0;
                    iter_cnt_d = cnt_inc;
`ifdef REPLICA_EXCH_ODD_EN
                    odd_d      = ~odd_q;
`else
                    odd_d      = 1'b0;
`endif
                    state_d    = (cnt_inc == iter_num_q) ? S_FIN : S_OPT_ISSUE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ph_q       <= '0;
            iter_cnt_q <= '0;
            iter_num_q <= '0;
            odd_q      <= 1'b0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            iter_cnt_q <= iter_cnt_d;
            iter_num_q <= iter_num_d;
            odd_q      <= odd_d;
            sel_q      <= sel_d;
        end
    end

    // Output decode: one command pulse per phase, straight from the registered state
    always_comb begin
        bus.command = '0;
        for (int k = 0; k < REPLICA_NUM; k++) begin
            if (state_q == S_OPT_ISSUE) begin
                bus.command[k] = CMD_OPT;
            end else if (state_q == S_EXC_ISSUE) begin
                bus.command[k] = CMD_EXC;
            end else begin
                bus.command[k] = CMD_NOP;
            end
        end
    end

    assign bus.busy     = (state_q == S_OPT_ISSUE) || (state_q == S_OPT_RUN) ||
                          (state_q == S_EXC_ISSUE) || (state_q == S_EXC_RUN);
    assign bus.done     = (state_q == S_FIN);
    assign bus.exch_odd = odd_q;
    assign bus.iter_cnt = iter_cnt_q;
    assign bus.src_sel  = sel_q;

    // SEL_SELF is the all-zero encoding used for reset and idle selects
    logic unused_sel_self;
    assign unused_sel_self = ^SEL_SELF;
endmodule

// File: tb/tb_replica_ram_sched.sv
// Purpose: randomized check of replica_ram_sched against a cycle-timeline model of the run.
// Latency: outputs compared every cycle on the falling clock edge.
// Backpressure: n/a; host inputs are driven freely, including starts during a run.
module tb_replica_ram_sched;
    localparam int C  = 4;
    localparam int R  = 4;
    localparam int W  = 16;
    localparam int GW = R - 1;
    localparam int L  = C + 2;     // phase length
    localparam int P  = 2 * L;     // iteration length
`ifdef REPLICA_EXCH_ODD_EN
    localparam int ODD_EN = 1;
`else
    localparam int ODD_EN = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    replica_ram_sched_if #(.REPLICA_NUM(R), .ITER_W(W)) bus ();

    replica_ram_sched #(.CITY_NUM(C), .REPLICA_NUM(R), .ITER_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected src_sel for one exchange: granted pair k of the right parity swaps lanes k,k+1
    function automatic logic [2*R-1:0] decode(input logic [GW-1:0] g, input int par);
        logic [R-1:0][1:0] s;
        s = '0;
        for (int k = 0; k < R - 1; k++) begin
            if (g[k] && (k % 2 == par)) begin
                s[k]     = 2'd2;
                s[k + 1] = 2'd1;
            end
        end
        return s;
    endfunction

    // Model: a run is a timeline starting at the cycle T in which start was accepted
    bit              has_run = 0;
    int              run_t   = 0;
    int              run_n   = 0;
    int              prev_cnt = 0;
    int              prev_odd = 0;
    logic [GW-1:0]   g_of_iter [0:15];
    int              cyc = 0;

    initial begin
        int o, i, p;
        bit idle;
        logic            e_busy, e_done;
        int              e_odd, e_cnt;
        logic [2*R-1:0]  e_cmd, e_sel;
        forever begin
            @(negedge clk);
            e_busy = 0; e_done = 0; e_cmd = '0; e_sel = '0;
            e_cnt = prev_cnt; e_odd = prev_odd;
            if (!rst_n) begin
                e_cnt = 0; e_odd = 0;
            end else if (has_run) begin
                o = cyc - run_t;
                if (o >= 1) begin
                    if (run_n == 0) begin
                        e_cnt = 0; e_odd = 0; e_done = (o == 1);
                    end else if (o <= P * run_n) begin
                        i = (o - 1) / P;
                        p = (o - 1) % P;
                        e_busy = 1;
                        e_cnt  = i;
                        e_odd  = ODD_EN ? (i % 2) : 0;
                        if (p == 0) e_cmd = {R{2'd1}};
                        if (p == L) e_cmd = {R{2'd2}};
                        if (p > L)  e_sel = decode(g_of_iter[i], e_odd);
                    end else begin
                        e_cnt  = run_n;
                        e_odd  = ODD_EN ? (run_n % 2) : 0;
                        e_done = (o == P * run_n + 1);
                    end
                end
            end
            check("busy",     64'(bus.busy),     64'(e_busy));
            check("done",     64'(bus.done),     64'(e_done));
            check("exch_odd", 64'(bus.exch_odd), 64'(e_odd));
            check("iter_cnt", 64'(bus.iter_cnt), 64'(e_cnt));
            check("command",  64'(bus.command),  64'(e_cmd));
            check("src_sel",  64'(bus.src_sel),  64'(e_sel));
            // Advance the model with the inputs the DUT samples at the next rising edge
            if (!rst_n) begin
                has_run = 0; prev_cnt = 0; prev_odd = 0;
            end else begin
                idle = !has_run || ((cyc - run_t) >= ((run_n == 0) ? 2 : P * run_n + 2));
                if (idle && bus.start) begin
                    prev_cnt = e_cnt; prev_odd = e_odd;
                    has_run = 1; run_t = cyc; run_n = int'(bus.iter_num);
                end else if (has_run && run_n > 0) begin
                    o = cyc - run_t;
                    if (o >= 1 && o <= P * run_n && (o - 1) % P == L)
                        g_of_iter[(o - 1) / P] = bus.exch_grant;
                end
            end
            cyc++;
        end
    end

    // Stimulus with hand-computed spot checks
    initial begin
        bus.start = 1'b0; bus.iter_num = '0; bus.exch_grant = '0;
        repeat (3) tick();
        #2;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_cmd",  64'(bus.command), 64'(0));
        check("rst_sel",  64'(bus.src_sel), 64'(0));
        check("rst_cnt",  64'(bus.iter_cnt), 64'(0));
        tick(); rst_n = 1'b1;
        tick(); tick();

        // One iteration: OPT at T+1, EXC at T+7, done at T+13
        bus.start = 1'b1; bus.iter_num = W'(1);
        tick(); bus.start = 1'b0;
        #2; check("t1_opt", 64'(bus.command), 64'(8'h55));
        check("t1_busy", 64'(bus.busy), 64'(1));
        repeat (6) tick();
        #2; check("t7_exc", 64'(bus.command), 64'(8'hAA));
        repeat (5) tick();
        #2; check("t12_busy", 64'(bus.busy), 64'(1));
        tick();
        #2; check("t13_done", 64'(bus.done), 64'(1));
        check("t13_busy", 64'(bus.busy), 64'(0));
        check("t13_cnt", 64'(bus.iter_cnt), 64'(1));
        tick();
        #2; check("t14_done", 64'(bus.done), 64'(0));

        // Zero iterations: immediate done, no commands
        tick(); bus.start = 1'b1; bus.iter_num = W'(0);
        tick(); bus.start = 1'b0;
        #2; check("z_done", 64'(bus.done), 64'(1));
        check("z_busy", 64'(bus.busy), 64'(0));
        check("z_cmd",  64'(bus.command), 64'(0));
        tick();

        // Two iterations, full grants, grants toggled during EXC_RUN, restart attempt mid-run
        tick(); bus.start = 1'b1; bus.iter_num = W'(2);
        tick(); bus.start = 1'b0;
        for (int o = 1; o <= 25; o++) begin
            bus.start = (o == 10);
            if (o == 10) bus.iter_num = W'(1);
            bus.exch_grant = ((o - 1) % P == L) ? {GW{1'b1}} : GW'($urandom);
            #2;
            if (o <= 2 * P && (o - 1) % P > L) begin
                check("x_sel", 64'(bus.src_sel), (o <= P) ? 64'(8'h66) : ((ODD_EN != 0) ? 64'(8'h18) : 64'(8'h66)));
                check("x_odd", 64'(bus.exch_odd), (o <= P) ? 64'(0) : 64'(ODD_EN));
            end
            if (o == 13) check("x_nodone", 64'(bus.done), 64'(0));
            if (o == 25) check("x_done", 64'(bus.done), 64'(1));
            tick();
        end

        // Reset in the middle of EXC_RUN
        bus.start = 1'b1; bus.iter_num = W'(3);
        tick(); bus.start = 1'b0;
        repeat (8) tick();
        #1; check("r_prebusy", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("r_busy", 64'(bus.busy), 64'(0));
        check("r_cmd",  64'(bus.command), 64'(0));
        check("r_sel",  64'(bus.src_sel), 64'(0));
        check("r_done", 64'(bus.done), 64'(0));
        tick(); tick(); rst_n = 1'b1;
        tick();

        // Randomized traffic: sporadic starts (often while busy), random grants, rare resets
        for (int k = 0; k < 3000; k++) begin
            bus.exch_grant = GW'($urandom);
            bus.start      = ($urandom_range(0, 15) == 0);
            bus.iter_num   = W'($urandom_range(0, 3));
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            tick();
        end
        bus.start = 1'b0; rst_n = 1'b1;
        repeat (60) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
